// File: rtl/fc_ibuf.sv
// Input buffer for one MLP layer: collects upstream activation writes into a full
// vector, then streams it bit-serially (LSB plane first) into the CIM crossbar tiles.
module fc_ibuf #(
  parameter int DATA_SIZE     = 8,
  parameter int INPUT_NEURONS = 512,
  parameter int XBAR_SIZE     = 256,
  parameter int WRITE_WIDTH   = 16,
  parameter int V_CIM_TILES   = (INPUT_NEURONS + XBAR_SIZE - 1) / XBAR_SIZE,
  parameter int NUM_WRITES    = (INPUT_NEURONS + WRITE_WIDTH - 1) / WRITE_WIDTH,
  parameter int BIT_W         = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [WRITE_WIDTH-1:0][DATA_SIZE-1:0] i_data,
  input  logic                                  i_write_enable,
  input  logic                                  i_start,
  output logic                                  o_ready,
  input  logic                                  i_cim_ready,
  output logic [V_CIM_TILES-1:0][XBAR_SIZE-1:0] o_cim_data,
  output logic [BIT_W-1:0]                      o_cim_bit,
  output logic                                  o_cim_valid,
  output logic                                  o_cim_start,
  output logic                                  o_err
);

  localparam int                WCNT_W    = $clog2(NUM_WRITES + 1);
  localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(NUM_WRITES);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

  typedef enum logic [1:0] {
    s_ibuf_fill   = 2'd0,
    s_ibuf_wait   = 2'd1,
    s_ibuf_stream = 2'd2,
    s_ibuf_done   = 2'd3
  } state_e;

  state_e                                  state_q, state_d;
  logic [WCNT_W-1:0]                       wcnt_q, wcnt_d;
  logic [BIT_W-1:0]                        bit_q, bit_d;
  logic                                    err_q, err_d;
  logic                                    store_en;
  logic                                    clear_en;
  logic [INPUT_NEURONS-1:0][DATA_SIZE-1:0] mem_q, mem_d;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    bit_d    = bit_q;
    err_d    = err_q;
    store_en = 1'b0;
    clear_en = 1'b0;
    case (state_q)
      s_ibuf_fill: begin
        if (i_write_enable) begin
          if (wcnt_q < WCNT_FULL) begin
            store_en = 1'b1;
            wcnt_d   = wcnt_q + WCNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        // A same-cycle write is captured above before the start is acted on.
        if (i_start) state_d = i_cim_ready ? s_ibuf_stream : s_ibuf_wait;
      end
      s_ibuf_wait: begin
        if (i_write_enable || i_start) err_d = 1'b1;
        if (i_cim_ready) state_d = s_ibuf_stream;
      end
      s_ibuf_stream: begin
        if (i_write_enable || i_start) err_d = 1'b1;
        if (bit_q == BIT_LAST) begin
          bit_d   = '0;
          state_d = s_ibuf_done;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      s_ibuf_done: begin
        if (i_write_enable || i_start) err_d = 1'b1;
        clear_en = 1'b1;
        wcnt_d   = '0;
        state_d  = s_ibuf_fill;
      end
      default: begin
        bit_d   = '0;
        state_d = s_ibuf_fill;
      end
    endcase
  end

  // Element gi belongs to write gi/WRITE_WIDTH, lane gi%WRITE_WIDTH; lanes past the
  // end of the vector have no storage and are simply dropped.
  genvar gi, gj;
  generate
    for (gi = 0; gi < INPUT_NEURONS; gi++) begin : g_elem
      localparam int W_IDX = gi / WRITE_WIDTH;
      localparam int E_IDX = gi % WRITE_WIDTH;
      assign mem_d[gi] = clear_en ? '0 :
                         (store_en && (wcnt_q == WCNT_W'(W_IDX))) ? i_data[E_IDX] :
                         mem_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= s_ibuf_fill;
      wcnt_q  <= '0;
      bit_q   <= '0;
      err_q   <= 1'b0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign o_ready     = (state_q == s_ibuf_fill);
  assign o_cim_valid = (state_q == s_ibuf_stream);
  assign o_cim_start = (state_q == s_ibuf_done);
  assign o_cim_bit   = bit_q;
  assign o_err       = err_q;

  // Rows beyond the vector are padding and are tied low.
  generate
    for (gi = 0; gi < V_CIM_TILES; gi++) begin : g_tile
      for (gj = 0; gj < XBAR_SIZE; gj++) begin : g_row
        if (gi * XBAR_SIZE + gj < INPUT_NEURONS) begin : g_live
          assign o_cim_data[gi][gj] = o_cim_valid & mem_q[gi*XBAR_SIZE+gj][bit_q];
        end else begin : g_pad
          assign o_cim_data[gi][gj] = 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fc_ibuf.sv
// Bench for fc_ibuf: a default instance and a 300-neuron instance, each checked every
// cycle against a vector/timeline model, plus hand-computed expectations.
module tb_fc_ibuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [15:0][7:0] wdata;
  logic             we[2], st[2], crdy[2];
  logic             rdy_o[2], val_o[2], cst_o[2], err_o[2];
  logic [2:0]       bit_o[2];
  logic [511:0]     data_o[2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: mk = -1 accepting, 0 waiting for CIM, 1..8 streaming plane mk-1, 9 start pulse.
  int         mk[2];
  int         mw[2];
  bit         me[2];
  logic [7:0] mv[2][512];

  fc_ibuf dut0 (
    .clk(clk), .rst(rst), .i_data(wdata), .i_write_enable(we[0]), .i_start(st[0]),
    .o_ready(rdy_o[0]), .i_cim_ready(crdy[0]), .o_cim_data(data_o[0]), .o_cim_bit(bit_o[0]),
    .o_cim_valid(val_o[0]), .o_cim_start(cst_o[0]), .o_err(err_o[0])
  );

  fc_ibuf #(.INPUT_NEURONS(300)) dut1 (
    .clk(clk), .rst(rst), .i_data(wdata), .i_write_enable(we[1]), .i_start(st[1]),
    .o_ready(rdy_o[1]), .i_cim_ready(crdy[1]), .o_cim_data(data_o[1]), .o_cim_bit(bit_o[1]),
    .o_cim_valid(val_o[1]), .o_cim_start(cst_o[1]), .o_err(err_o[1])
  );

  function automatic int n_of(input int i);
    return (i == 1) ? 300 : 512;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        mk[i] = -1;
        mw[i] = 0;
        me[i] = 1'b0;
        for (int x = 0; x < 512; x++) mv[i][x] = 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mk[i] == -1) begin
          if (we[i]) begin
            if (mw[i] < (n_of(i) + 15) / 16) begin
              for (int e = 0; e < 16; e++)
                if (mw[i] * 16 + e < n_of(i)) mv[i][mw[i]*16+e] = wdata[e];
              mw[i] = mw[i] + 1;
            end else begin
              me[i] = 1'b1;
            end
          end
          if (st[i]) mk[i] = crdy[i] ? 1 : 0;
        end else begin
          if (we[i] || st[i]) me[i] = 1'b1;
          if (mk[i] == 0) begin
            if (crdy[i]) mk[i] = 1;
          end else if (mk[i] == 9) begin
            for (int x = 0; x < 512; x++) mv[i][x] = 8'h00;
            mw[i] = 0;
            mk[i] = -1;
          end else begin
            mk[i] = mk[i] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, i, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic [511:0] ed;
      int           k;
      bit           strm;
      k    = mk[i];
      strm = (k >= 1 && k <= 8);
      ed   = '0;
      if (strm) for (int x = 0; x < n_of(i); x++) ed[x] = mv[i][x][k-1];
      chk("ready", i, 512'(rdy_o[i]), 512'(k == -1));
      chk("valid", i, 512'(val_o[i]), 512'(strm));
      chk("bit", i, 512'(bit_o[i]), 512'(strm ? k - 1 : 0));
      chk("start", i, 512'(cst_o[i]), 512'(k == 9));
      chk("err", i, 512'(err_o[i]), 512'(me[i]));
      chk("data", i, data_o[i], ed);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int i, input bit s);
    we[i] = 1'b1;
    st[i] = s;
    tick();
    we[i] = 1'b0;
    st[i] = 1'b0;
  endtask

  task automatic do_start(input int i);
    st[i] = 1'b1;
    tick();
    st[i] = 1'b0;
  endtask

  task automatic fill_rand(input int i, input int n);
    for (int w = 0; w < n; w++) begin
      for (int e = 0; e < 16; e++) wdata[e] = 8'($urandom);
      do_write(i, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_ready(input int i);
    for (int n = 0; n < 60 && rdy_o[i] !== 1'b1; n++) tick();
    chk("ready_timeout", i, 512'(rdy_o[i]), 512'(1));
  endtask

  // Called right after the edge that launched streaming: plane j in cycle T+1+j.
  task automatic expect_stream(input int i, input int mode);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("plane_valid", i, 512'(val_o[i]), 512'(1));
      chk("plane_bit", i, 512'(bit_o[i]), 512'(j));
      if (mode == 1) begin
        chk("elem255", i, 512'(data_o[i][255]), 512'(1));
        chk("elem256", i, 512'(data_o[i][256]), 512'(0));
        chk("elem1", i, 512'(data_o[i][1]), 512'(j == 0));
      end else if (mode == 2) begin
        chk("tile1_row43", i, 512'(data_o[i][299]), 512'(1));
        chk("tile1_row44", i, 512'(data_o[i][300]), 512'(0));
        chk("partial_err", i, 512'(err_o[i]), 512'(0));
      end else if (mode == 3) begin
        chk("zero_plane", i, data_o[i], 512'(0));
      end
    end
    @(negedge clk);
    chk("start_pulse", i, 512'(cst_o[i]), 512'(1));
    @(negedge clk);
    chk("ready_again", i, 512'(rdy_o[i]), 512'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b0;
    wdata = '0;
    for (int i = 0; i < 2; i++) begin
      we[i]   = 1'b0;
      st[i]   = 1'b0;
      crdy[i] = 1'b1;
    end
    fork
      forever begin
        @(negedge clk);
        if (cmp_en) compare_all();
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b1;
    cmp_en = 1'b1;

    // Full vector: element k = k mod 256, start on the 32nd write.
    for (int w = 0; w < 32; w++) begin
      for (int e = 0; e < 16; e++) wdata[e] = 8'((w * 16 + e) % 256);
      do_write(0, w == 31);
    end
    expect_stream(0, 1);

    // Partial last write on the 300-neuron instance.
    for (int e = 0; e < 16; e++) wdata[e] = 8'hFF;
    for (int w = 0; w < 19; w++) do_write(1, w == 18);
    expect_stream(1, 2);

    // Overflow write: flagged, stored vector unchanged.
    do_reset();
    fill_rand(0, 32);
    for (int e = 0; e < 16; e++) wdata[e] = 8'($urandom);
    do_write(0, 1'b0);
    @(negedge clk);
    chk("err_overflow", 0, 512'(err_o[0]), 512'(1));
    tick();
    do_start(0);
    wait_ready(0);

    // Asynchronous reset mid-stream at plane 3.
    fill_rand(0, 8);
    do_start(0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", 0, 512'(rdy_o[0]), 512'(1));
    chk("rst_valid", 0, 512'(val_o[0]), 512'(0));
    chk("rst_start", 0, 512'(cst_o[0]), 512'(0));
    chk("rst_data", 0, data_o[0], 512'(0));
    chk("rst_err", 0, 512'(err_o[0]), 512'(0));
    tick();
    rst = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      chk("no_start_after_rst", 0, 512'(cst_o[0]), 512'(0));
    end
    tick();
    do_start(0);
    expect_stream(0, 3);

    // Write during streaming: flagged, planes unaffected.
    do_reset();
    fill_rand(0, 5);
    do_start(0);
    tick();
    for (int e = 0; e < 16; e++) wdata[e] = 8'($urandom);
    do_write(0, 1'b0);
    @(negedge clk);
    chk("err_stream_write", 0, 512'(err_o[0]), 512'(1));
    tick();
    wait_ready(0);

    // CIM backpressure held for 5 cycles.
    do_reset();
    fill_rand(0, 10);
    crdy[0] = 1'b0;
    do_start(0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_valid", 0, 512'(val_o[0]), 512'(0));
      chk("bp_ready", 0, 512'(rdy_o[0]), 512'(0));
    end
    tick();
    crdy[0] = 1'b1;
    tick();
    expect_stream(0, 0);

    // Randomized vectors on both instances.
    for (int r = 0; r < 50; r++) begin
      int i, nw, nwr;
      bit sep;
      i   = $urandom_range(0, 1);
      nw  = (n_of(i) + 15) / 16;
      nwr = $urandom_range(0, nw + 1);
      sep = 1'($urandom_range(0, 1));
      crdy[i] = ($urandom_range(0, 2) != 0);
      for (int w = 0; w < nwr; w++) begin
        for (int e = 0; e < 16; e++) wdata[e] = 8'($urandom);
        do_write(i, !sep && (w == nwr - 1));
      end
      if (sep || nwr == 0) do_start(i);
      if (!crdy[i]) begin
        repeat ($urandom_range(1, 4)) tick();
        if ($urandom_range(0, 3) == 0) do_write(i, 1'b0);
        crdy[i] = 1'b1;
      end
      wait_ready(i);
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_ibuf.md
Name: fc_ibuf

Overview:
- Input-buffer receiver for one MLP layer; it is the write-side counterpart of the fc_func unit.
- Accepts WRITE_WIDTH activations per cycle from the upstream func unit and assembles a full INPUT_NEURONS vector.
- On the upstream start it streams the vector bit-serially, LSB plane first, into V_CIM_TILES crossbar tiles, then pulses the CIM start.

Parameters:
- DATA_SIZE, 8: activation width in bits; one bit-plane is sent per stream cycle.
- INPUT_NEURONS, 512: elements in this layer's input vector.
- XBAR_SIZE, 256: crossbar rows per tile.
- WRITE_WIDTH, 16: elements per upstream write (upstream H_CIM_TILES*NUM_CHANNELS).
- V_CIM_TILES, (INPUT_NEURONS+XBAR_SIZE-1)/XBAR_SIZE: number of vertical tiles fed.
- NUM_WRITES, (INPUT_NEURONS+WRITE_WIDTH-1)/WRITE_WIDTH: writes that make up one vector.
- BIT_W, (DATA_SIZE>1)?$clog2(DATA_SIZE):1: width of the bit-plane index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_data  in  [DATA_SIZE-1:0] x WRITE_WIDTH  upstream activations; element e of write w maps to vector index w*WRITE_WIDTH+e.
- i_write_enable  in  1  i_data valid this cycle.
- i_start  in  1  upstream vector-complete pulse; may coincide with the last write.
- o_ready  out  1  buffer accepting a new vector.
- i_cim_ready  in  1  CIM able to accept input planes.
- o_cim_data  out  [XBAR_SIZE-1:0] x V_CIM_TILES  current bit-plane; bit r of tile v is bit o_cim_bit of element v*XBAR_SIZE+r.
- o_cim_bit  out  BIT_W  plane index currently driven.
- o_cim_valid  out  1  o_cim_data is a valid plane.
- o_cim_start  out  1  one-cycle pulse after the last plane.
- o_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to s_ibuf_fill; write count 0; bit count 0; all storage 0; o_err 0.
  - Outputs: o_ready=1, o_cim_valid=0, o_cim_start=0, o_cim_bit=0, o_cim_data all 0.
- State machine. All outputs are decoded combinationally from state and registers.
- s_ibuf_fill (o_ready=1):
  - A write with write count < NUM_WRITES stores the elements of that write whose index is < INPUT_NEURONS; the rest are dropped. Write count increments.
  - A write with write count = NUM_WRITES is ignored and sets o_err.
  - i_start: the same-cycle write is captured first. Then go to s_ibuf_stream if i_cim_ready=1, otherwise to s_ibuf_wait.
  - i_start with write count 0 (and no same-cycle write) is still honoured and streams the all-zero vector.
- s_ibuf_wait (o_ready=0): go to s_ibuf_stream on i_cim_ready=1.
- s_ibuf_stream (o_ready=0):
  - o_cim_valid=1 and o_cim_bit = bit count, for DATA_SIZE consecutive cycles (bit 0 first).
  - The stream does not stall once started; i_cim_ready is ignored here.
  - After bit DATA_SIZE-1, go to s_ibuf_done.
- s_ibuf_done (o_ready=0): o_cim_start=1 for exactly one cycle. Storage and write count are cleared synchronously. Next state is s_ibuf_fill.
- Latency: with i_start and i_cim_ready both high at edge T:
  - Planes 0..DATA_SIZE-1 appear in cycles T+1..T+DATA_SIZE.
  - o_cim_start is high in cycle T+DATA_SIZE+1.
  - o_ready is 1 again from T+DATA_SIZE+2.
- Padding: rows for indices >= INPUT_NEURONS and rows never written always drive 0.
- Any i_write_enable or i_start outside s_ibuf_fill is ignored, sets o_err and leaves storage untouched.
- o_err clears only on reset.
- Reset mid-operation aborts immediately. No o_cim_start is emitted, and the partial vector is lost.
- Unused default state: outputs as in reset; next state is s_ibuf_fill.

Test Plan:
- Reset check: assert rst=0 asynchronously mid-cycle -> outputs go to reset values immediately: o_ready=1, o_cim_valid=0, o_cim_start=0, o_cim_data=0, o_err=0.
- Full vector (defaults): 32 writes with element k = k mod 256, i_start on the 32nd write, i_cim_ready=1:
  - Cycles T+1..T+8 have o_cim_valid=1 and o_cim_bit 0..7, with o_cim_data[v][r] = bit b of ((v*256+r) mod 256).
  - o_cim_start pulses at T+9; o_ready=1 at T+10.
- CIM backpressure: i_cim_ready=0 at i_start and held low 5 cycles -> o_cim_valid stays 0 and o_ready=0 throughout; streaming starts the cycle after i_cim_ready rises.
- Partial last write (INPUT_NEURONS=300, WRITE_WIDTH=16):
  - 19 writes of all-0xFF -> 4 elements dropped.
  - Tile 1 rows 0..43 are 1 and rows 44..255 are 0 in every plane; o_err stays 0.
- Protocol errors, each checked from a fresh reset:
  - A 33rd write with default parameters sets o_err=1 and stored data is unchanged.
  - A write during s_ibuf_stream sets o_err=1 and the streamed planes are unaffected.
- Reset mid-stream: rst low at plane 3 -> no o_cim_start. A following i_start with no writes streams all-zero planes and then pulses o_cim_start.
